// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks every output position and kernel tap of one
// feature map, handing input/weight addresses to the MAC over valid/ready,
// then strobes the result write for each finished window.
// Optional build macro STALL_CNT_EN adds a 32-bit stall_cycles output that
// counts cycles where a tap is offered but not taken.
module conv_window_scheduler #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 10,
  localparam int OUT_W = (IMG_W - K) / STRIDE + 1,
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1,
  localparam int WA_W  = (K > 1) ? $clog2(K * K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic [ADDR_W-1:0] in_addr,
  output logic [WA_W-1:0]   w_addr,
  output logic              acc_clr,
  output logic              acc_last,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [WA_W-1:0]   K_W    = WA_W'(K);
  localparam logic [WA_W-1:0]   K_LAST = WA_W'(K - 1);
  localparam logic [ADDR_W-1:0] S_A    = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] IW_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OW_A   = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] OW_L   = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] OH_L   = ADDR_W'(OUT_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ox;
  logic [ADDR_W-1:0] oy;
  logic [WA_W-1:0]   kx;
  logic [WA_W-1:0]   ky;
  logic              run_q;
  logic              we_q;
  logic              done_q;
  logic              busy_q;
  logic              accept;

  // Strobes are registered with the state; en gates them so a frozen
  // scheduler neither offers taps nor writes nor signals completion.
  always_comb begin
    tap_valid = run_q & en;
    out_we    = we_q & en;
    done      = done_q & en;
    busy      = busy_q;
    accept    = tap_valid & tap_ready;
    acc_clr   = tap_valid & (kx == '0) & (ky == '0);
    acc_last  = tap_valid & (kx == K_LAST) & (ky == K_LAST);
    in_addr   = (oy * S_A + ADDR_W'(ky)) * IW_A + ox * S_A + ADDR_W'(kx);
    w_addr    = ky * K_W + kx;
    out_addr  = oy * OW_A + ox;
  end

  // Main sequencer: tap walk inside a window, one write per window,
  // single-cycle done at the end of the map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ox     <= '0;
      oy     <= '0;
      kx     <= '0;
      ky     <= '0;
      run_q  <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            run_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (kx == K_LAST) begin
              kx <= '0;
              if (ky == K_LAST) begin
                ky    <= '0;
                state <= WRITE;
                run_q <= 1'b0;
                we_q  <= 1'b1;
              end else begin
                ky <= ky + 1'b1;
              end
            end else begin
              kx <= kx + 1'b1;
            end
          end
        end
        WRITE: begin
          we_q <= 1'b0;
          if (ox == OW_L && oy == OH_L) begin
            ox     <= '0;
            oy     <= '0;
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            if (ox == OW_L) begin
              ox <= '0;
              oy <= oy + 1'b1;
            end else begin
              ox <= ox + 1'b1;
            end
            state <= RUN;
            run_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          ox     <= '0;
          oy     <= '0;
          kx     <= '0;
          ky     <= '0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          run_q <= 1'b0;
          we_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of offered-but-refused taps; restarts with each pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (en && state == IDLE && start) begin
      stall_cycles <= '0;
    end else if (tap_valid && !tap_ready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench for conv_window_scheduler: two 5x5/K3 instances
// (stride 1 and stride 2). Expected taps and write addresses are queued
// when a pass is started and popped as the DUT accepts taps / writes.
module tb_conv_window_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en0, en1, start0, start1, rdy0, rdy1;
  logic busy0, done0, tv0, clr0, last0, we0;
  logic busy1, done1, tv1, clr1, last1, we1;
  logic [9:0] ia0, oa0, ia1, oa1;
  logic [3:0] wa0, wa1;
`ifdef STALL_CNT_EN
  logic [31:0] sc0, sc1;
`endif

  conv_window_scheduler #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(1), .ADDR_W(10)) u_s1 (
`ifdef STALL_CNT_EN
    .stall_cycles(sc0),
`endif
    .clk(clk), .rst(rst), .en(en0), .start(start0), .busy(busy0), .done(done0),
    .tap_valid(tv0), .tap_ready(rdy0), .in_addr(ia0), .w_addr(wa0),
    .acc_clr(clr0), .acc_last(last0), .out_we(we0), .out_addr(oa0)
  );

  conv_window_scheduler #(.IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2), .ADDR_W(10)) u_s2 (
`ifdef STALL_CNT_EN
    .stall_cycles(sc1),
`endif
    .clk(clk), .rst(rst), .en(en1), .start(start1), .busy(busy1), .done(done1),
    .tap_valid(tv1), .tap_ready(rdy1), .in_addr(ia1), .w_addr(wa1),
    .acc_clr(clr1), .acc_last(last1), .out_we(we1), .out_addr(oa1)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] q_tap [2][$];
  logic [9:0]  q_out [2][$];
  int          busy_cnt [2];
  int          lost [2];
  int          last_lost [2];
  int          done_cnt [2];
  int          exp_cycles [2];
  logic        prev_stall [2];
  logic [15:0] prev_vec [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Queue every tap and write of a 5x5 / K3 pass at the given stride.
  task automatic push_pass(input int id, input int stride);
    int ow;
    int ia;
    int wa;
    logic [9:0] oa;
    ow = (5 - 3) / stride + 1;
    for (int oy = 0; oy < ow; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        for (int ky = 0; ky < 3; ky++) begin
          for (int kx = 0; kx < 3; kx++) begin
            ia = (oy * stride + ky) * 5 + ox * stride + kx;
            wa = ky * 3 + kx;
            q_tap[id].push_back({ia[9:0], wa[3:0], (ky == 0 && kx == 0), (ky == 2 && kx == 2)});
          end
        end
        oa = 10'(oy * ow + ox);
        q_out[id].push_back(oa);
      end
    end
  endtask

  task automatic monitor(input int id, input logic rst_i, input logic en_i, input logic rdy_i,
                         input logic busy_i, input logic done_i, input logic tv_i,
                         input logic clr_i, input logic last_i, input logic we_i,
                         input logic [9:0] ia, input logic [9:0] oa, input logic [3:0] wa);
    logic [15:0] vec;
    logic [15:0] e_tap;
    logic [9:0]  e_out;
    vec = {ia, wa, clr_i, last_i};
    if (rst_i) begin
      check("rst_outputs", {2'b00, busy_i, done_i, tv_i, clr_i, last_i, we_i, ia, oa, wa}, 32'h0);
      busy_cnt[id] = 0;
      lost[id] = 0;
      prev_stall[id] = 1'b0;
      return;
    end
    if (!en_i) check("en_low_gating", {29'h0, tv_i, we_i, done_i}, 32'h0);
    if (prev_stall[id]) check("stall_hold", {16'h0, vec}, {16'h0, prev_vec[id]});
    prev_stall[id] = tv_i && !rdy_i;
    prev_vec[id] = vec;
    if (busy_i) begin
      busy_cnt[id]++;
      if (!en_i || (tv_i && !rdy_i)) lost[id]++;
    end
    if (tv_i && rdy_i) begin
      if (q_tap[id].size() == 0) check("tap_unexpected", q_tap[id].size(), 1);
      else begin
        e_tap = q_tap[id].pop_front();
        check("tap", {16'h0, vec}, {16'h0, e_tap});
      end
    end
    if (we_i) begin
      if (q_out[id].size() == 0) check("write_unexpected", q_out[id].size(), 1);
      else begin
        e_out = q_out[id].pop_front();
        check("out_addr", {22'h0, oa}, {22'h0, e_out});
      end
    end
    if (done_i) begin
      check("done_queues_empty", q_tap[id].size() + q_out[id].size(), 0);
      check("pass_cycles", busy_cnt[id] - lost[id], exp_cycles[id]);
      done_cnt[id]++;
      last_lost[id] = lost[id];
      busy_cnt[id] = 0;
      lost[id] = 0;
    end
  endtask

  always @(negedge clk) begin
    monitor(0, rst, en0, rdy0, busy0, done0, tv0, clr0, last0, we0, ia0, oa0, wa0);
    monitor(1, rst, en1, rdy1, busy1, done1, tv1, clr1, last1, we1, ia1, oa1, wa1);
  end

  task automatic do_start(input int id, input int stride);
    push_pass(id, stride);
    @(posedge clk); #1;
    if (id == 0) start0 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget);
    int d;
    int n;
    d = done_cnt[id];
    n = 0;
    while (done_cnt[id] == d && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", done_cnt[id] - d, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d;
    rst = 1'b1;
    en0 = 1'b1; en1 = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1;
    exp_cycles[0] = 91;
    exp_cycles[1] = 41;
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0; lost[i] = 0; last_lost[i] = 0; done_cnt[i] = 0;
      prev_stall[i] = 1'b0; prev_vec[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
`ifdef STALL_CNT_EN
    check("stall_cnt_reset", sc0, 0);
`endif

    // Stride 1, full-speed pass
    do_start(0, 1);
    wait_done(0, 300);
    check("busy_after_done", {31'h0, busy0}, 0);

    // Stride 2 pass
    do_start(1, 2);
    wait_done(1, 200);

    // Backpressure: five refused cycles mid-window of position 1
    do_start(0, 1);
    repeat (14) @(posedge clk);
    #1 rdy0 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rdy0 = 1'b1;
    wait_done(0, 300);
    check("stall_lost_cycles", last_lost[0], 5);
`ifdef STALL_CNT_EN
    check("stall_cycles", sc0, 5);
`endif

    // Enable low for three cycles during RUN
    do_start(0, 1);
    repeat (22) @(posedge clk);
    #1 en0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 en0 = 1'b1;
    wait_done(0, 300);
    check("en_lost_cycles", last_lost[0], 3);
`ifdef STALL_CNT_EN
    check("stall_cleared_on_start", sc0, 0);
`endif

    // Reset during position 4, then restart
    do_start(0, 1);
    repeat (42) @(posedge clk);
    #1 rst = 1'b1;
    d = done_cnt[0];
    q_tap[0].delete();
    q_out[0].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("no_done_on_reset", done_cnt[0], d);
`ifdef STALL_CNT_EN
    check("stall_cnt_after_rst", sc0, 0);
`endif
    do_start(0, 1);
    wait_done(0, 300);

    // start while busy is ignored; exactly one done; then a fresh pass
    do_start(0, 1);
    d = done_cnt[0];
    repeat (30) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done(0, 300);
    repeat (30) @(posedge clk);
    #1;
    check("single_done", done_cnt[0] - d, 1);
    check("idle_after_ignored_start", {31'h0, busy0}, 0);
    do_start(0, 1);
    wait_done(0, 300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
